any1_issue_ctrl: RTL and testbench

Issue controller between the ANY-1 wakeup logic and the execution units. Each cycle it takes the vector of woken reorder-buffer entries and routes up to one entry to each of three units: ALU, flow-control (FCU) and memory (MEM). Each unit has a registered valid/ready issue port. Issued entries are held in a pending mask until the ROB reports them out, which closes the one-cycle window where an entry is woken but its out flag is not yet visible.

---
 rtl/any1_issue_ctrl_if.sv | 36 +++
 rtl/any1_issue_ctrl.sv | 141 ++++++++++++++
 tb/tb_any1_issue_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/any1_issue_ctrl_if.sv
// Issue-port bundle between the ANY-1 wakeup/ROB side and the ALU/FCU/MEM execution units.
// master: issue controller; slave: ROB/exec side that drives wakeup state and ready.
interface any1_issue_ctrl_if #(
  parameter int ROB_ENTRIES = 64,
  parameter int RID_W       = 6
);
  logic                     flush_i;
  logic [RID_W-1:0]         head_i;
  logic [ROB_ENTRIES-1:0]   wakeup_i;
  logic [2*ROB_ENTRIES-1:0] class_i;
  logic [ROB_ENTRIES-1:0]   out_i;
  logic                     alu_rdy_i;
  logic                     fcu_rdy_i;
  logic                     mem_rdy_i;
  logic                     alu_v_o;
  logic                     fcu_v_o;
  logic                     mem_v_o;
  logic [RID_W-1:0]         alu_rid_o;
  logic [RID_W-1:0]         fcu_rid_o;
  logic [RID_W-1:0]         mem_rid_o;
  logic [ROB_ENTRIES-1:0]   pending_o;

  modport master (
    input  flush_i, head_i, wakeup_i, class_i, out_i,
    input  alu_rdy_i, fcu_rdy_i, mem_rdy_i,
    output alu_v_o, fcu_v_o, mem_v_o,
    output alu_rid_o, fcu_rid_o, mem_rid_o, pending_o
  );

  modport slave (
    output flush_i, head_i, wakeup_i, class_i, out_i,
    output alu_rdy_i, fcu_rdy_i, mem_rdy_i,
    input  alu_v_o, fcu_v_o, mem_v_o,
    input  alu_rid_o, fcu_rid_o, mem_rid_o, pending_o
  );
endinterface

// File: rtl/any1_issue_ctrl.sv
// ANY-1 issue controller: routes woken ROB entries to ALU/FCU/MEM ports and tracks pending issues.
// ANY1_ISSUE_AGE_EN: defined = oldest-first from head_i, undefined = lowest index wins.

module any1_issue_port #(
  parameter int ROB_ENTRIES = 64,
  parameter int RID_W       = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush,
  input  logic [RID_W-1:0]       head,
  input  logic [ROB_ENTRIES-1:0] cand,
  input  logic                   rdy,
  output logic                   v,
  output logic [RID_W-1:0]       rid,
  output logic [ROB_ENTRIES-1:0] set_mask
);
  localparam logic [RID_W-1:0] MASK = RID_W'(ROB_ENTRIES - 1);

  typedef enum logic {IDLE, HOLD} state_t;
  state_t state, state_nxt;

  logic [RID_W-1:0]       base, off, win;
  logic [ROB_ENTRIES-1:0] rot;
  logic                   have, load;

`ifdef ANY1_ISSUE_AGE_EN
  logic [2*ROB_ENTRIES-1:0] dbl;
  // Rotate so head lands at bit 0; the lowest set bit is then the oldest entry.
  assign base = head & MASK;
  assign dbl  = {cand, cand} >> base;
  assign rot  = dbl[ROB_ENTRIES-1:0];
`else
  logic unused_head;
  assign unused_head = ^head;
  assign base        = '0;
  assign rot         = cand;
`endif

  always_comb begin
    off = '0;
    for (int i = ROB_ENTRIES - 1; i >= 0; i--)
      if (rot[i]) off = RID_W'(i);
  end

  assign win  = (base + off) & MASK;
  assign have = |cand;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: if (have) begin
        state_nxt = HOLD;
        load      = 1'b1;
      end
      HOLD: if (rdy) begin
        state_nxt = have ? HOLD : IDLE;
        load      = have;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = IDLE;
      load      = 1'b0;
    end
  end

  always_comb begin
    set_mask = '0;
    if (load) set_mask[win] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      rid   <= '0;
    end else begin
      state <= state_nxt;
      if (load) rid <= win;
    end
  end

  assign v = (state == HOLD);
endmodule

module any1_issue_ctrl #(
  parameter int ROB_ENTRIES = 64,
  parameter int RID_W       = 6
) (
  input logic              clk_i,
  input logic              rst_i,
  any1_issue_ctrl_if.master bus
);
  localparam int UNITS = 3;  // 0 ALU, 1 FCU, 2 MEM; matches the class encoding

  logic [UNITS-1:0][ROB_ENTRIES-1:0] cand, set_m;
  logic [UNITS-1:0][RID_W-1:0]       rid;
  logic [UNITS-1:0]                  rdy, v;
  logic [ROB_ENTRIES-1:0]            pending, set_all;

  assign rdy = {bus.mem_rdy_i, bus.fcu_rdy_i, bus.alu_rdy_i};

  always_comb begin
    cand = '0;
    for (int u = 0; u < UNITS; u++)
      for (int n = 0; n < ROB_ENTRIES; n++)
        cand[u][n] = bus.wakeup_i[n] & ~pending[n] & ~bus.out_i[n] &
                     (bus.class_i[2*n +: 2] == 2'(u));
  end

  for (genvar u = 0; u < UNITS; u++) begin : g_port
    any1_issue_port #(.ROB_ENTRIES(ROB_ENTRIES), .RID_W(RID_W)) u_port (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .flush    (bus.flush_i),
      .head     (bus.head_i),
      .cand     (cand[u]),
      .rdy      (rdy[u]),
      .v        (v[u]),
      .rid      (rid[u]),
      .set_mask (set_m[u])
    );
  end

  assign set_all = set_m[0] | set_m[1] | set_m[2];

  // Set after clear so a same-cycle set/clear on one bit keeps it pending.
  always_ff @(posedge clk_i) begin
    if (rst_i || bus.flush_i) pending <= '0;
    else                      pending <= (pending & ~bus.out_i) | set_all;
  end

  assign bus.alu_v_o   = v[0];
  assign bus.fcu_v_o   = v[1];
  assign bus.mem_v_o   = v[2];
  assign bus.alu_rid_o = rid[0];
  assign bus.fcu_rid_o = rid[1];
  assign bus.mem_rid_o = rid[2];
  assign bus.pending_o = pending;
endmodule

// File: tb/tb_any1_issue_ctrl.sv
// Directed bench for any1_issue_ctrl: reset, ordering, age wrap, stall, parallel issue, flush.
module tb_any1_issue_ctrl;
  localparam int N = 64;
  localparam int W = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  any1_issue_ctrl_if #(.ROB_ENTRIES(N), .RID_W(W)) bus ();
  any1_issue_ctrl #(.ROB_ENTRIES(N), .RID_W(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cls(input int n, input logic [1:0] c);
    bus.class_i[2*n +: 2] = c;
  endtask

  function automatic logic [63:0] bits3(input int a, input int b, input int c);
    logic [63:0] m;
    m = '0;
    m[a] = 1'b1; m[b] = 1'b1; m[c] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] bit1(input int a);
    logic [63:0] m;
    m = '0;
    m[a] = 1'b1;
    return m;
  endfunction

  initial begin
    bus.flush_i   = 1'b0;
    bus.head_i    = '0;
    bus.wakeup_i  = '0;
    bus.class_i   = '1;
    bus.out_i     = '0;
    bus.alu_rdy_i = 1'b1;
    bus.fcu_rdy_i = 1'b1;
    bus.mem_rdy_i = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset state and idle
    chk("rst_alu_v", 64'(bus.alu_v_o), 64'd0);
    chk("rst_fcu_v", 64'(bus.fcu_v_o), 64'd0);
    chk("rst_mem_v", 64'(bus.mem_v_o), 64'd0);
    chk("rst_alu_rid", 64'(bus.alu_rid_o), 64'd0);
    chk("rst_fcu_rid", 64'(bus.fcu_rid_o), 64'd0);
    chk("rst_mem_rid", 64'(bus.mem_rid_o), 64'd0);
    chk("rst_pending", bus.pending_o, 64'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_v", 64'({bus.alu_v_o, bus.fcu_v_o, bus.mem_v_o}), 64'd0);
      chk("idle_pending", bus.pending_o, 64'd0);
    end

    // ALU entries 5 and 9, head 0
    set_cls(5, 2'd0); set_cls(9, 2'd0);
    bus.wakeup_i = bit1(5) | bit1(9);
    tick();
    chk("alu1_v", 64'(bus.alu_v_o), 64'd1);
    chk("alu1_rid", 64'(bus.alu_rid_o), 64'd5);
    chk("alu1_pend", bus.pending_o, bit1(5));
    tick();
    chk("alu2_v", 64'(bus.alu_v_o), 64'd1);
    chk("alu2_rid", 64'(bus.alu_rid_o), 64'd9);
    chk("alu2_pend", bus.pending_o, bit1(5) | bit1(9));
    tick();
    chk("alu3_no_reissue", 64'(bus.alu_v_o), 64'd0);
    chk("alu3_pend", bus.pending_o, bit1(5) | bit1(9));
    bus.out_i = bit1(5);
    tick();
    chk("alu4_pend_clr5", bus.pending_o, bit1(9));
    chk("alu4_v", 64'(bus.alu_v_o), 64'd0);
    bus.wakeup_i = '0;
    bus.out_i    = bit1(9);
    tick();
    chk("alu5_pend", bus.pending_o, 64'd0);
    bus.out_i   = '0;
    bus.class_i = '1;

    // MEM age wrap across 63 -> 0
    bus.head_i = 6'd62;
    set_cls(1, 2'd2); set_cls(63, 2'd2);
    bus.wakeup_i = bit1(1) | bit1(63);
    tick();
    chk("wrap1_v", 64'(bus.mem_v_o), 64'd1);
`ifdef ANY1_ISSUE_AGE_EN
    chk("wrap1_rid", 64'(bus.mem_rid_o), 64'd63);
`else
    chk("wrap1_rid", 64'(bus.mem_rid_o), 64'd1);
`endif
    tick();
    chk("wrap2_v", 64'(bus.mem_v_o), 64'd1);
`ifdef ANY1_ISSUE_AGE_EN
    chk("wrap2_rid", 64'(bus.mem_rid_o), 64'd1);
`else
    chk("wrap2_rid", 64'(bus.mem_rid_o), 64'd63);
`endif
    chk("wrap2_pend", bus.pending_o, bit1(1) | bit1(63));
    bus.wakeup_i = '0;
    bus.out_i    = bit1(1) | bit1(63);
    tick();
    chk("wrap3_v", 64'(bus.mem_v_o), 64'd0);
    chk("wrap3_pend", bus.pending_o, 64'd0);
    bus.out_i   = '0;
    bus.class_i = '1;
    bus.head_i  = '0;

    // FCU stall on entry 12
    set_cls(12, 2'd1);
    bus.fcu_rdy_i = 1'b0;
    bus.wakeup_i  = bit1(12);
    tick();
    chk("stall0_v", 64'(bus.fcu_v_o), 64'd1);
    chk("stall0_rid", 64'(bus.fcu_rid_o), 64'd12);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_v", 64'(bus.fcu_v_o), 64'd1);
      chk("stall_rid", 64'(bus.fcu_rid_o), 64'd12);
    end
    bus.fcu_rdy_i = 1'b1;
    tick();
    chk("stall_release_v", 64'(bus.fcu_v_o), 64'd0);
    bus.wakeup_i = '0;
    bus.out_i    = bit1(12);
    tick();
    chk("stall_pend", bus.pending_o, 64'd0);
    bus.out_i   = '0;
    bus.class_i = '1;

    // Parallel issue, then flush while all ports stalled
    set_cls(3, 2'd0); set_cls(4, 2'd1); set_cls(7, 2'd2);
    bus.alu_rdy_i = 1'b0; bus.fcu_rdy_i = 1'b0; bus.mem_rdy_i = 1'b0;
    bus.wakeup_i  = bits3(3, 4, 7);
    tick();
    chk("par_v", 64'({bus.alu_v_o, bus.fcu_v_o, bus.mem_v_o}), 64'h7);
    chk("par_alu_rid", 64'(bus.alu_rid_o), 64'd3);
    chk("par_fcu_rid", 64'(bus.fcu_rid_o), 64'd4);
    chk("par_mem_rid", 64'(bus.mem_rid_o), 64'd7);
    chk("par_pend", bus.pending_o, bits3(3, 4, 7));
    bus.flush_i = 1'b1;
    tick();
    chk("flush_v", 64'({bus.alu_v_o, bus.fcu_v_o, bus.mem_v_o}), 64'h0);
    chk("flush_pend", bus.pending_o, 64'd0);
    bus.flush_i = 1'b0;
    tick();
    chk("reissue_v", 64'({bus.alu_v_o, bus.fcu_v_o, bus.mem_v_o}), 64'h7);
    chk("reissue_rids", 64'({bus.alu_rid_o, bus.fcu_rid_o, bus.mem_rid_o}),
        64'({6'd3, 6'd4, 6'd7}));
    chk("reissue_pend", bus.pending_o, bits3(3, 4, 7));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
